gpr_scoreboard: RTL and testbench

- Tracks outstanding writes to the 32 general-purpose registers for the pipelined MIPS core.
- Sits beside the register file on the read side (decode stage):
  - decode presents the instruction's source and destination registers;
  - write-back reports each completed register write, on the same wr/we the register file consumes.
- Produces the decode stall signal and per-source bypass indications.
- Holds a stall-cycle performance counter.

---
 rtl/gpr_scoreboard.sv | 70 +++++++
 tb/tb_gpr_scoreboard.sv | 126 ++++++++++++
 2 files changed

// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard: tracks in-flight GPR writes and produces decode stall, bypass selects and a stall counter
module gpr_scoreboard #(
    parameter int LAT_W  = 3,
    parameter int PEND_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_we,
    input  logic [4:0]       id_wr,
    input  logic [LAT_W-1:0] id_lat,
    input  logic             wb_we,
    input  logic [4:0]       wb_wr,
    output logic             stall,
    output logic             rs_bypass,
    output logic             rt_bypass,
    output logic [31:0]      stall_count
);
    localparam logic [PEND_W-1:0] PMAX = '1;
    logic [PEND_W-1:0] pend   [32];
    logic [PEND_W-1:0] pend_n [32];
    logic [LAT_W-1:0]  cnt    [32];
    logic [LAT_W-1:0]  cnt_n  [32];
    logic [31:0] inc, dec;
    logic rs_live, rt_live, rs_haz, rt_haz, dst_full, issue;
    // hazard and bypass decisions from pre-edge state; register 0 is never live
    always_comb begin
        rs_live   = id_use_rs && id_rs != 5'd0 && pend[id_rs] != '0;
        rt_live   = id_use_rt && id_rt != 5'd0 && pend[id_rt] != '0;
        rs_haz    = rs_live && cnt[id_rs] != '0;
        rt_haz    = rt_live && cnt[id_rt] != '0;
        dst_full  = id_we && id_wr != 5'd0 && pend[id_wr] == PMAX;
        stall     = id_valid && (rs_haz || rt_haz || dst_full);
        rs_bypass = id_valid && rs_live && cnt[id_rs] == '0;
        rt_bypass = id_valid && rt_live && cnt[id_rt] == '0;
        issue     = id_valid && !stall && id_we && id_wr != 5'd0;
    end
    // next state per register: newest issue reloads the countdown, an emptied entry clears it
    always_comb begin
        pend_n = '{default: '0};
        cnt_n  = '{default: '0};
        inc    = '0;
        dec    = '0;
        for (int r = 1; r < 32; r++) begin
            inc[r]    = issue && id_wr == 5'(r);
            dec[r]    = wb_we && wb_wr == 5'(r) && pend[r] != '0;
            pend_n[r] = (inc[r] && !dec[r]) ? pend[r] + PEND_W'(1) :
                        (dec[r] && !inc[r]) ? pend[r] - PEND_W'(1) : pend[r];
            cnt_n[r]  = pend_n[r] == '0 ? '0 :
                        inc[r] ? id_lat :
                        cnt[r] != '0 ? cnt[r] - LAT_W'(1) : '0;
        end
    end
    // state registers and free-running stall counter
    always_ff @(posedge clk) begin
        if (reset) begin
            pend        <= '{default: '0};
            cnt         <= '{default: '0};
            stall_count <= '0;
        end else begin
            pend        <= pend_n;
            cnt         <= cnt_n;
            stall_count <= stall_count + 32'(stall);
        end
    end
endmodule

// File: tb/tb_gpr_scoreboard.sv
// tb_gpr_scoreboard: scoreboard bench comparing gpr_scoreboard against a behavioural model
module tb_gpr_scoreboard;
    logic        clk = 0, reset = 1;
    logic        id_valid = 0, id_use_rs = 0, id_use_rt = 0, id_we = 0, wb_we = 0;
    logic [4:0]  id_rs = 0, id_rt = 0, id_wr = 0, wb_wr = 0;
    logic [2:0]  id_lat = 0;
    logic        stall, rs_bypass, rt_bypass;
    logic [31:0] stall_count;
    int          n_cmp = 0, n_err = 0;
    logic [2:0]  exp_q[$];
    int          mp[32], mc[32];
    logic [31:0] msc = 0;

    gpr_scoreboard #(.LAT_W(3), .PEND_W(2)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_we(id_we), .id_wr(id_wr),
        .id_lat(id_lat), .wb_we(wb_we), .wb_wr(wb_wr), .stall(stall),
        .rs_bypass(rs_bypass), .rt_bypass(rt_bypass), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic hz(input logic [4:0] x, input logic u);
        return u && x != 0 && mp[x] != 0 && mc[x] != 0;
    endfunction

    function automatic logic bp(input logic [4:0] x, input logic u);
        return u && x != 0 && mp[x] != 0 && mc[x] == 0;
    endfunction

    // one clock: drive, predict, compare, then advance the model with the same inputs
    task automatic cyc(input string tag, input logic rst, input logic v,
                       input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt,
                       input logic we, input logic [4:0] wr, input logic [2:0] lat,
                       input logic wbe, input logic [4:0] wbr);
        logic st, iss, inc, dec;
        reset = rst; id_valid = v; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
        id_we = we; id_wr = wr; id_lat = lat; wb_we = wbe; wb_wr = wbr;
        st = v && (hz(rs, urs) || hz(rt, urt) || (we && wr != 0 && mp[wr] == 3));
        exp_q.push_back({st, v && bp(rs, urs), v && bp(rt, urt)});
        #2;
        check({tag, " stall/rsb/rtb"}, {29'd0, stall, rs_bypass, rt_bypass}, {29'd0, exp_q.pop_front()});
        check({tag, " stall_count"}, stall_count, msc);
        @(posedge clk);
        if (rst) begin
            foreach (mp[r]) begin mp[r] = 0; mc[r] = 0; end
            msc = 0;
        end else begin
            iss = v && !st && we && wr != 0;
            for (int r = 1; r < 32; r++) begin
                inc = iss && wr == 5'(r);
                dec = wbe && wbr == 5'(r) && mp[r] != 0;
                if (inc && !dec) mp[r]++;
                else if (dec && !inc) mp[r]--;
                mc[r] = inc ? int'(lat) : (mc[r] != 0 ? mc[r] - 1 : 0);
                if (mp[r] == 0) mc[r] = 0;
            end
            if (st) msc++;
        end
        #1;
    endtask

    task automatic idle(input string tag);
        cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        // reads with nothing outstanding
        cyc("clean", 0, 1, 5, 1, 6, 1, 0, 0, 0, 0, 0);
        // single producer lat=2: stall, bypass, then read from register file after write-back
        cyc("iss8", 0, 1, 0, 0, 0, 0, 1, 8, 2, 0, 0);
        cyc("rd8a", 0, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("rd8b", 0, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("rd8c", 0, 1, 8, 1, 8, 1, 0, 0, 0, 1, 8);
        cyc("rd8d", 0, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0);
        // register 0 and invalid decode never hazard
        cyc("r0", 0, 1, 0, 1, 0, 1, 1, 0, 7, 0, 0);
        cyc("inv", 0, 0, 0, 0, 0, 0, 1, 12, 7, 0, 0);
        cyc("inv12", 0, 0, 12, 1, 12, 1, 0, 0, 0, 0, 0);
        // two producers of 9
        cyc("iss9a", 0, 1, 0, 0, 0, 0, 1, 9, 1, 0, 0);
        cyc("iss9b", 0, 1, 0, 0, 0, 0, 1, 9, 3, 0, 0);
        cyc("wb9", 0, 1, 9, 1, 0, 0, 0, 0, 0, 1, 9);
        for (int i = 0; i < 3; i++) cyc("rd9", 0, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0);
        cyc("wb9b", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
        cyc("wb9x", 0, 1, 9, 1, 0, 0, 0, 0, 0, 1, 9);
        // pending counter saturation on 10
        for (int i = 0; i < 3; i++) cyc("iss10", 0, 1, 0, 0, 0, 0, 1, 10, 0, 0, 0);
        cyc("full10", 0, 1, 0, 0, 0, 0, 1, 10, 0, 1, 10);
        cyc("free10", 0, 1, 0, 0, 0, 0, 1, 10, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc("wb10", 0, 1, 10, 1, 0, 0, 0, 0, 0, 1, 10);
        // issue and write-back of 11 in one cycle, then stray write-backs
        cyc("iss11", 0, 1, 0, 0, 0, 0, 1, 11, 0, 0, 0);
        cyc("iwb11", 0, 1, 0, 0, 0, 0, 1, 11, 2, 1, 11);
        cyc("rd11", 0, 1, 11, 1, 0, 0, 0, 0, 0, 1, 0);
        cyc("rd11b", 0, 1, 11, 1, 0, 0, 0, 0, 0, 1, 20);
        cyc("rd11c", 0, 1, 11, 1, 11, 1, 0, 0, 0, 0, 0);
        // long stall, reset mid-stall, stale write-back afterwards
        cyc("iss13", 0, 1, 0, 0, 0, 0, 1, 13, 7, 0, 0);
        for (int i = 0; i < 5; i++) cyc("hold13", 0, 1, 13, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("rst", 1, 1, 13, 1, 0, 0, 1, 14, 3, 0, 0);
        cyc("post", 0, 1, 13, 1, 11, 1, 0, 0, 0, 1, 13);
        cyc("post2", 0, 1, 13, 1, 0, 0, 1, 13, 1, 0, 0);
        cyc("post3", 0, 1, 13, 1, 13, 1, 0, 0, 0, 0, 0);
        // random traffic over a few registers
        for (int i = 0; i < 400; i++)
            cyc("rnd", i == 200, 1'($urandom_range(0, 3) != 0),
                5'($urandom_range(0, 5)), 1'($urandom), 5'($urandom_range(0, 5)), 1'($urandom),
                1'($urandom), 5'($urandom_range(0, 5)), 3'($urandom), 1'($urandom),
                5'($urandom_range(0, 5)));
        idle("end");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
